// File: rtl/newton_pkg.sv
`default_nettype none
// ============================================================================
// Module   : newton_pkg
// Purpose  : Shared definitions for the digit-serial Newton reciprocal engine:
//            SD digit encodings, FSM state type, digit decode and clipping.
// Revision : 1.0 - initial release
// ============================================================================
package newton_pkg;

    // Signed-digit encodings; 2'b10 is unused and decodes as zero
    localparam logic [1:0] SD_ZERO = 2'b00;
    localparam logic [1:0] SD_POS  = 2'b01;
    localparam logic [1:0] SD_NEG  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ITER = 2'd2,
        ST_EMIT = 2'd3
    } state_t;

    // Decode one SD digit into a signed -1/0/+1
    function automatic logic signed [1:0] sd_val(input logic [1:0] digit);
        case (digit)
            SD_POS:  sd_val = 2'sd1;
            SD_NEG:  sd_val = -2'sd1;
            default: sd_val = 2'sd0;
        endcase
    endfunction

    // Clip a wide signed value into a w-bit two's-complement range
    function automatic logic signed [63:0] sat_clip(input logic signed [63:0] v,
                                                    input int unsigned     w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_stream_acc.sv
`default_nettype none
// ============================================================================
// Module   : sd_stream_acc
// Purpose  : MSB-first signed-digit to two's-complement accumulator with
//            synchronous clear and frame restart.
// Revision : 1.0 - initial release
// ============================================================================
module sd_stream_acc #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              asyn_reset,
    input  logic              clear,
    input  logic              en,
    input  logic              restart,
    input  logic [1:0]        digit,
    output logic signed [WIDTH:0] acc
);
    import newton_pkg::*;

    logic signed [1:0]     w_d;
    logic signed [WIDTH:0] w_d_ext;

    assign w_d     = sd_val(digit);
    assign w_d_ext = {{(WIDTH - 1){w_d[1]}}, w_d};

    // Horner accumulation: a restart digit seeds the value, others shift in
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (en)
            acc <= restart ? w_d_ext : ((acc <<< 1) + w_d_ext);
    end

endmodule
`default_nettype wire

// File: rtl/newton_sd_recip.sv
`default_nettype none
// ============================================================================
// Module   : newton_sd_recip
// Purpose  : Digit-serial Newton-Raphson reciprocal engine. Loads SD operands
//            x0 and b, runs ITERS iterations of x <- x*(2 - b*x) in fixed
//            point with saturation, and streams the result back out as SD
//            digits under a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module newton_sd_recip
    import newton_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FRAC  = 6,
    parameter int ITERS = 2
) (
    input  logic       clk,
    input  logic       asyn_reset,
    input  logic       in_valid,
    input  logic       in_start,
    input  logic [1:0] x_digit,
    input  logic [1:0] b_digit,
    output logic       in_ready,
    input  logic       out_ready,
    output logic       out_valid,
    output logic       out_start,
    output logic       out_last,
    output logic [1:0] res,
    output logic       sat
);

    localparam int PW  = 2 * WIDTH + 2;
    localparam int NIT = (ITERS == 0) ? 1 : ITERS;
    localparam int LCW = $clog2(WIDTH + 1);
    localparam int OCW = $clog2(WIDTH);

    localparam logic [LCW-1:0]       C_LOAD_LAST = LCW'(WIDTH - 1);
    localparam logic [3:0]           C_ITER_LAST = 4'(NIT - 1);
    localparam logic [OCW-1:0]       C_OUT_LAST  = OCW'(WIDTH - 1);
    localparam logic [OCW-1:0]       C_OUT_PENUL = OCW'(WIDTH - 2);
    localparam logic signed [PW-1:0] C_TWO       = PW'(2 << FRAC);

    state_t                r_state;
    logic [LCW-1:0]        r_load_cnt;
    logic [3:0]            r_iter_cnt;
    logic [OCW-1:0]        r_out_cnt;
    logic signed [WIDTH:0] r_x;
    logic [WIDTH-1:0]      r_word;

    logic                  w_accept;
    logic                  w_out_xfer;
    logic                  w_acc_clear;
    logic signed [WIDTH:0] w_acc_x;
    logic signed [WIDTH:0] w_acc_b;
    logic signed [WIDTH:0] w_x_cur;
    logic signed [PW-1:0]  w_xe;
    logic signed [PW-1:0]  w_be;
    logic signed [PW-1:0]  w_prod_bx;
    logic signed [PW-1:0]  w_t;
    logic signed [PW-1:0]  w_u;
    logic signed [PW-1:0]  w_prod_xu;
    logic signed [PW-1:0]  w_y;
    logic signed [63:0]    w_y64;
    logic signed [63:0]    w_clip;
    logic                  w_sat_hit;
    logic signed [WIDTH:0] w_x_next;

    // A digit is taken in IDLE only when it opens a frame; in LOAD always
    assign w_accept    = in_valid && in_ready && (in_start || (r_state == ST_LOAD));
    assign w_out_xfer  = out_valid && out_ready;
    assign w_acc_clear = (r_state == ST_EMIT) && w_out_xfer && (r_out_cnt == C_OUT_LAST);

    sd_stream_acc #(.WIDTH(WIDTH)) u_acc_x (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .clear      (w_acc_clear),
        .en         (w_accept),
        .restart    (in_start),
        .digit      (x_digit),
        .acc        (w_acc_x)
    );

    sd_stream_acc #(.WIDTH(WIDTH)) u_acc_b (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .clear      (w_acc_clear),
        .en         (w_accept),
        .restart    (in_start),
        .digit      (b_digit),
        .acc        (w_acc_b)
    );

    // The first iteration reads x0 straight from the accumulator, which
    // avoids a copy cycle between LOAD and ITER. b stays frozen in its
    // accumulator because no digits are accepted while iterating.
    assign w_x_cur   = (r_iter_cnt == 4'd0) ? w_acc_x : r_x;
    assign w_xe      = {{(PW - WIDTH - 1){w_x_cur[WIDTH]}}, w_x_cur};
    assign w_be      = {{(PW - WIDTH - 1){w_acc_b[WIDTH]}}, w_acc_b};
    assign w_prod_bx = w_be * w_xe;
    assign w_t       = w_prod_bx >>> FRAC;
    assign w_u       = C_TWO - w_t;
    assign w_prod_xu = w_xe * w_u;
    assign w_y       = (ITERS == 0) ? w_xe : (w_prod_xu >>> FRAC);
    assign w_y64     = {{(64 - PW){w_y[PW-1]}}, w_y};
    assign w_clip    = sat_clip(w_y64, WIDTH);
    assign w_sat_hit = (w_clip != w_y64);
    assign w_x_next  = w_clip[WIDTH:0];

    // Frame sequencing, iteration state and registered stream outputs
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            r_state    <= ST_IDLE;
            r_load_cnt <= '0;
            r_iter_cnt <= '0;
            r_out_cnt  <= '0;
            r_x        <= '0;
            r_word     <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_start  <= 1'b0;
            out_last   <= 1'b0;
            res        <= SD_ZERO;
            sat        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    if (w_accept) begin
                        if (in_start) begin
                            r_load_cnt <= LCW'(1);
                            r_state    <= ST_LOAD;
                            sat        <= 1'b0;
                        end else if (r_load_cnt == C_LOAD_LAST) begin
                            r_load_cnt <= '0;
                            r_iter_cnt <= '0;
                            in_ready   <= 1'b0;
                            r_state    <= ST_ITER;
                        end else begin
                            r_load_cnt <= r_load_cnt + LCW'(1);
                        end
                    end
                end
                ST_ITER: begin
                    r_x <= w_x_next;
                    if (w_sat_hit)
                        sat <= 1'b1;
                    if (r_iter_cnt == C_ITER_LAST) begin
                        r_state    <= ST_EMIT;
                        r_iter_cnt <= '0;
                        r_out_cnt  <= '0;
                        // Digit 0 carries the negative sign weight; the rest
                        // queue up in r_word for plain 0/+1 emission
                        r_word     <= {w_x_next[WIDTH-2:0], 1'b0};
                        res        <= w_x_next[WIDTH-1] ? SD_NEG : SD_ZERO;
                        out_valid  <= 1'b1;
                        out_start  <= 1'b1;
                        out_last   <= 1'b0;
                    end else begin
                        r_iter_cnt <= r_iter_cnt + 4'd1;
                    end
                end
                ST_EMIT: begin
                    if (w_out_xfer) begin
                        if (r_out_cnt == C_OUT_LAST) begin
                            r_state   <= ST_IDLE;
                            r_out_cnt <= '0;
                            out_valid <= 1'b0;
                            out_start <= 1'b0;
                            out_last  <= 1'b0;
                            res       <= SD_ZERO;
                            in_ready  <= 1'b1;
                        end else begin
                            r_out_cnt <= r_out_cnt + OCW'(1);
                            res       <= r_word[WIDTH-1] ? SD_POS : SD_ZERO;
                            r_word    <= r_word << 1;
                            out_start <= 1'b0;
                            out_last  <= (r_out_cnt == C_OUT_PENUL);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_newton_sd_recip.sv
`default_nettype none
// ============================================================================
// Module   : tb_newton_sd_recip
// Purpose  : Directed self-checking bench for newton_sd_recip
//            (WIDTH=8, FRAC=6, ITERS=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_newton_sd_recip;

    logic       clk = 1'b0;
    logic       asyn_reset;
    logic       in_valid;
    logic       in_start;
    logic [1:0] x_digit;
    logic [1:0] b_digit;
    logic       in_ready;
    logic       out_ready;
    logic       out_valid;
    logic       out_start;
    logic       out_last;
    logic [1:0] res;
    logic       sat;

    int n_vec = 0;
    int n_err = 0;

    newton_sd_recip #(.WIDTH(8), .FRAC(6), .ITERS(2)) dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .in_valid   (in_valid),
        .in_start   (in_start),
        .x_digit    (x_digit),
        .b_digit    (b_digit),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_start  (out_start),
        .out_last   (out_last),
        .res        (res),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    // Hard stop in case the flow gets stuck somewhere unforeseen
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_start"}, 32'(out_start), 32'd0);
        chk({tag, "_out_last"},  32'(out_last),  32'd0);
        chk({tag, "_res"},       32'(res),       32'd0);
        chk({tag, "_sat"},       32'(sat),       32'd0);
    endtask

    // Drive one frame MSB-first; returns on the first negedge after the last digit
    task automatic send_frame(input logic [15:0] xd, input logic [15:0] bd,
                              input bit gaps, input bit sat_clr);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 1 && sat_clr)
                chk("sat_clear", 32'(sat), 32'd0);
            in_valid = 1'b1;
            in_start = (i == 0);
            x_digit  = xd[15 - 2*i -: 2];
            b_digit  = bd[15 - 2*i -: 2];
            if (gaps && (i == 1 || i == 4)) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_start = 1'b0;
                x_digit  = 2'b10;
                b_digit  = 2'b01;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_start = 1'b0;
    endtask

    // Count negedges (the current one is 1) until out_valid rises
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid)
            chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic collect(input string tag, input int stall_at, input bit exp_sat,
                           output logic [15:0] dig);
        int         n      = 0;
        int         guard  = 0;
        int         stalls = 0;
        logic [1:0] held   = 2'b00;
        dig = '0;
        while (n < 8 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (n == stall_at && stalls < 3) begin
                out_ready = 1'b0;
                if (stalls == 0)
                    held = res;
                else
                    chk({tag, "_hold"}, 32'(res), 32'(held));
                chk({tag, "_stall_valid"},    32'(out_valid), 32'd1);
                chk({tag, "_stall_in_ready"}, 32'(in_ready),  32'd0);
                stalls++;
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    chk({tag, "_start"}, 32'(out_start), 32'(n == 0));
                    chk({tag, "_last"},  32'(out_last),  32'(n == 7));
                    if (n == 0)
                        chk({tag, "_sat"}, 32'(sat), 32'(exp_sat));
                    dig[15 - 2*n -: 2] = res;
                    n++;
                end
            end
        end
        if (n != 8)
            chk({tag, "_collect_count"}, 32'(n), 32'd8);
    endtask

    task automatic run_frame(input string tag, input logic [15:0] xd, input logic [15:0] bd,
                             input bit gaps, input int stall_at, input logic [15:0] exp_dig,
                             input bit exp_sat, input bit sat_clr);
        int          lat;
        logic [15:0] dig;
        send_frame(xd, bd, gaps, sat_clr);
        chk({tag, "_iter_in_ready"}, 32'(in_ready), 32'd0);
        wait_out(lat);
        if (!gaps)
            chk({tag, "_latency"}, 32'(lat), 32'd3);
        collect(tag, stall_at, exp_sat, dig);
        chk({tag, "_res"}, 32'(dig), 32'(exp_dig));
        @(negedge clk);
        chk({tag, "_done_in_ready"},  32'(in_ready),  32'd1);
        chk({tag, "_done_out_valid"}, 32'(out_valid), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        asyn_reset = 1'b1;
        in_valid   = 1'b0;
        in_start   = 1'b0;
        x_digit    = 2'b00;
        b_digit    = 2'b00;
        out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        asyn_reset = 1'b0;

        // Digits without in_start while idle are dropped
        @(negedge clk);
        in_valid = 1'b1;
        in_start = 1'b0;
        x_digit  = 2'b01;
        b_digit  = 2'b11;
        repeat (2) @(negedge clk);

        // x0=80, b=48 -> 86
        run_frame("canon",  16'h1100, 16'h0500, 1'b0, -1, 16'h1114, 1'b0, 1'b0);
        // x0 = 0,1,1,-1,0,0,0,0 = 80 -> 86
        run_frame("redund", 16'h1700, 16'h0500, 1'b0, -1, 16'h1114, 1'b0, 1'b0);
        // x0=127, b=-64 -> clips to 127
        run_frame("satpos", 16'h1555, 16'hD000, 1'b0, -1, 16'h1555, 1'b1, 1'b0);
        // x0=-80, b=48 -> clips to -128; sat from previous frame clears
        run_frame("satneg", 16'h3300, 16'h0500, 1'b0, -1, 16'hC000, 1'b1, 1'b1);
        // Backpressure for 3 cycles at digit 4
        run_frame("bp",     16'h1100, 16'h0500, 1'b0,  4, 16'h1114, 1'b0, 1'b1);

        // Five digits of a junk frame, then a restart with input gaps
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_start = (i == 0);
            x_digit  = 2'b01;
            b_digit  = 2'b11;
        end
        run_frame("restart", 16'h1100, 16'h0500, 1'b1, -1, 16'h1114, 1'b0, 1'b0);

        // Reset during ITER of a saturating frame
        send_frame(16'h1555, 16'hD000, 1'b0, 1'b0);
        @(negedge clk);
        chk("iter_sat_live", 32'(sat), 32'd1);
        #2 asyn_reset = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_iter");
        asyn_reset = 1'b0;

        // Reset during EMIT after a few digits have gone out
        send_frame(16'h1100, 16'h0500, 1'b0, 1'b0);
        wait_out(lat);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("emit_valid_before_rst", 32'(out_valid), 32'd1);
        #2 asyn_reset = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_emit");
        out_ready  = 1'b0;
        asyn_reset = 1'b0;

        run_frame("post_rst", 16'h1100, 16'h0500, 1'b0, -1, 16'h1114, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
